// File: rtl/hfrv_mem_arbiter.sv
// Two-port SRAM arbiter: core vs. debug/loader, round robin on conflict,
// bounded loader burst priority under d_lock, one-cycle read response routing.
module hfrv_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic [AW-1:0]     c_addr,
  input  logic [DW/8-1:0]   c_be,
  input  logic [DW-1:0]     c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DW-1:0]     c_rdata,
  input  logic              d_req,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW/8-1:0]   d_be,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  input  logic              d_lock,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {OWN_C = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [7:0] MAX_RUN = MAX_BURST[7:0];

  owner_e      owner_q, owner_d;
  owner_e      resp_owner_q, resp_owner_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  run_q, run_d;
  logic [15:0] conflict_q, conflict_d;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (c_req && d_req) begin
        if (d_lock) begin
          if (run_q < MAX_RUN) d_gnt = 1'b1;
          else                 c_gnt = 1'b1;
        end else if (owner_q == OWN_D) begin
          c_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = c_gnt | d_gnt;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_be    = c_be;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_be    = d_be;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    owner_d      = owner_q;
    run_d        = run_q;
    resp_valid_d = 1'b0;
    resp_owner_d = resp_owner_q;
    conflict_d   = conflict_q;
    if (c_gnt)      owner_d = OWN_C;
    else if (d_gnt) owner_d = OWN_D;
    // run_cnt only counts loader grants that made the core wait.
    if (c_gnt || !c_req)                 run_d = '0;
    else if (d_gnt && run_q != 8'hFF)    run_d = run_q + 8'd1;
    if (mem_en && mem_be == '0) begin
      resp_valid_d = 1'b1;
      resp_owner_d = d_gnt ? OWN_D : OWN_C;
    end
    if (c_req && d_req && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_D;
      run_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_C;
      conflict_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      run_q        <= run_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      conflict_q   <= conflict_d;
    end
  end

  // Response gated by rst so a read granted just before reset never returns.
  assign c_rvalid     = resp_valid_q && resp_owner_q == OWN_C && !rst;
  assign d_rvalid     = resp_valid_q && resp_owner_q == OWN_D && !rst;
  assign c_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Scoreboard bench for hfrv_mem_arbiter: directed grant vectors, queued read
// responses checked by an independent monitor.
module tb_hfrv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, d_req, d_lock;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [15:0] conflict_cnt;

  typedef struct {logic own; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_conf = 0;

  hfrv_mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_be(c_be), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_lock(d_lock),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // SRAM model: one-cycle read latency, garbage otherwise.
  always @(posedge clk)
    mem_rdata <= (mem_en && mem_be == 4'b0) ? mfn(mem_addr) : 32'h0BAD0BAD;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic cr, input logic [31:0] ca, input logic [3:0] cbe,
                      input logic [31:0] cw, input logic dr, input logic [31:0] da,
                      input logic [3:0] dbe, input logic [31:0] dw, input logic lk,
                      input logic r, input logic [1:0] eg, input string nm);
    exp_t e;
    c_req = cr; c_addr = ca; c_be = cbe; c_wdata = cw;
    d_req = dr; d_addr = da; d_be = dbe; d_wdata = dw;
    d_lock = lk; rst = r;
    @(negedge clk);
    if (r) begin
      while (q.size() > 0 && q[q.size()-1].cyc == cyc) void'(q.pop_back());
      chk({nm, "_rvalid"}, {70'b0, c_rvalid, d_rvalid}, 72'b0);
      exp_conf = 0;
    end else if (cr && dr && exp_conf < 65535) begin
      exp_conf++;
    end
    chk({nm, "_gnt"}, {70'b0, c_gnt, d_gnt}, {70'b0, eg});
    chk({nm, "_en"}, {71'b0, mem_en}, {71'b0, |eg});
    if (eg == 2'b10)
      chk({nm, "_mem"}, {4'b0, mem_addr, mem_be, mem_wdata}, {4'b0, ca, cbe, cw});
    else if (eg == 2'b01)
      chk({nm, "_mem"}, {4'b0, mem_addr, mem_be, mem_wdata}, {4'b0, da, dbe, dw});
    else
      chk({nm, "_mem"}, {4'b0, mem_addr, mem_be, mem_wdata}, 72'b0);
    if (!r && eg == 2'b10 && cbe == 4'b0) begin
      e.own = 1'b0; e.data = mfn(ca); e.cyc = cyc + 1; q.push_back(e);
    end else if (!r && eg == 2'b01 && dbe == 4'b0) begin
      e.own = 1'b1; e.data = mfn(da); e.cyc = cyc + 1; q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, r, 2'b00, "idle");
  endtask

  // Response monitor, offset from the stimulus sample point.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (c_rvalid || d_rvalid) begin
      checks++;
      if (c_rvalid && d_rvalid) begin
        errors++;
        $display("FAIL rvalid_both @cyc %0d: got c=1 d=1 expected one", cyc);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexp @cyc %0d: got c=%0b d=%0b expected none", cyc, c_rvalid, d_rvalid);
      end else begin
        e = q.pop_front();
        if (d_rvalid !== e.own || (d_rvalid ? d_rdata : c_rdata) !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rresp @cyc %0d: got own=%0b data=%h expected own=%0b data=%h cyc=%0d",
                   cyc, d_rvalid, d_rvalid ? d_rdata : c_rdata, e.own, e.data, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL rvalid_missing @cyc %0d: got none expected own=%0b cyc=%0d", cyc, e.own, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; d_lock = 1'b0;
    c_req = 1'b0; c_addr = '0; c_be = '0; c_wdata = '0;
    d_req = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++)
      step(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 0, 1, 2'b00, "rst");
    chk("rst_conf", {56'b0, conflict_cnt}, 72'd0);
    step(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 0, 0, 2'b10, "first");
    idle(0);
    chk("conf_first", {56'b0, conflict_cnt}, 72'(exp_conf));

    for (int i = 0; i < 3; i++)
      step(1, 32'h100 + 32'(4*i), 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, "core_rd");
    idle(0);
    step(0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 0, 2'b01, "ld_rd");

    for (int i = 0; i < 6; i++)
      step(1, 32'h500 + 32'(4*i), 0, 0, 1, 32'h600 + 32'(4*i), 0, 0, 0, 0,
           (i % 2 == 0) ? 2'b10 : 2'b01, "rr");
    idle(0);
    chk("conf_rr", {56'b0, conflict_cnt}, 72'd7);

    for (int i = 0; i < 10; i++)
      step(1, 32'h700 + 32'(4*i), 0, 0, 1, 32'h800 + 32'(4*i), 0, 0, 1, 0,
           (i == 4 || i == 9) ? 2'b10 : 2'b01, "lock");
    step(1, 32'h780, 0, 0, 1, 32'h880, 0, 0, 0, 0, 2'b01, "unlock");
    idle(0);
    chk("conf_lock", {56'b0, conflict_cnt}, 72'(exp_conf));

    step(0, 0, 0, 0, 1, 32'h200, 4'b0011, 32'hDEADBEEF, 0, 0, 2'b01, "ld_wr");
    step(0, 0, 0, 0, 1, 32'h200, 4'b0000, 32'h0, 0, 0, 2'b01, "ld_rd2");
    step(1, 32'h204, 4'b1111, 32'h12345678, 1, 32'h208, 0, 0, 0, 0, 2'b10, "c_wr");
    step(0, 0, 0, 0, 1, 32'h208, 0, 0, 0, 0, 2'b01, "ld_rd3");
    idle(0);

    step(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, "rd_pre_rst");
    idle(1);
    idle(0);
    chk("conf_after_rst", {56'b0, conflict_cnt}, 72'd0);

    c_req = 1; c_be = 4'hF; c_addr = 32'h900; d_req = 1; d_be = 4'hF; d_addr = 32'hA00;
    repeat (65534) @(posedge clk);
    #1 chk("conf_fffe", {56'b0, conflict_cnt}, 72'h0FFFE);
    repeat (6) @(posedge clk);
    #1 chk("conf_sat", {56'b0, conflict_cnt}, 72'h0FFFF);
    idle(0);
    idle(0);
    chk("conf_hold", {56'b0, conflict_cnt}, 72'h0FFFF);

    idle(0);
    chk("sb_empty", 72'(q.size()), 72'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
